// File: rtl/instr_inv_queue.sv
// Pending instruction-memory invalidation queue feeding the branch predictor.
// Circular buffer with coalescing of repeated non-head addresses.
module instr_inv_queue #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 30
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [ADDR_W-1:0]          push_addr,
    input  logic                       clear,
    output logic                       inv_valid,
    output logic [ADDR_W-1:0]          inv_addr,
    input  logic                       inv_completed,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [ADDR_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;
    logic              r_overflow;

    logic              w_pop;
    logic              w_do_clear;
    logic              w_hit;
    logic              w_coal;
    logic              w_take;
    logic              w_room;
    logic              w_acc;
    logic              w_drop;
    logic [PW-1:0]     w_head_nxt;
    logic [PW-1:0]     w_tail_mid;
    logic [CW-1:0]     w_cnt_mid;
    logic [PW-1:0]     w_slot [DEPTH];

    assign w_pop      = inv_completed & (r_count != '0);
    assign w_do_clear = clear & (r_count != '0);
    assign w_head_nxt = r_head + PW'(w_pop);

    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        assign w_slot[g] = r_head + PW'(g);
    end

    // Only entries behind the head take part in coalescing.
    always_comb begin
        w_hit = 1'b0;
        for (int i = 1; i < DEPTH; i++) begin
            if ((CW'(i) < r_count) &&
                (r_mem[w_slot[i]] == push_addr)) begin
                w_hit = 1'b1;
            end
        end
    end

    // A clear drops every non-head entry, so nothing is left to coalesce into.
    assign w_coal = w_hit & ~clear;

    always_comb begin
        w_cnt_mid  = r_count - CW'(w_pop);
        w_tail_mid = r_tail;
        if (w_do_clear) begin
            w_cnt_mid  = w_pop ? '0 : CW'(1);
            w_tail_mid = r_head + PW'(1);
        end
    end

    assign w_take = push & ~w_coal;
    assign w_room = (w_cnt_mid != DEPTH_C);
    assign w_acc  = w_take & w_room;
    assign w_drop = w_take & ~w_room;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_head     <= w_head_nxt;
            r_tail     <= w_tail_mid + PW'(w_acc);
            r_count    <= w_cnt_mid + CW'(w_acc);
            r_overflow <= r_overflow | w_drop;
        end
    end

    // Entry storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (!rst && w_acc) begin
            r_mem[w_tail_mid] <= push_addr;
        end
    end

    assign inv_valid = (r_count != '0);
    assign inv_addr  = r_mem[r_head];
    assign full      = (r_count == DEPTH_C);
    assign count     = r_count;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_instr_inv_queue.sv
// Self-checking bench for instr_inv_queue against a queue-based model.
module tb_instr_inv_queue;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 30;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              push = 1'b0;
    logic [ADDR_W-1:0] push_addr = '0;
    logic              clear = 1'b0;
    logic              inv_completed = 1'b0;
    logic              inv_valid;
    logic [ADDR_W-1:0] inv_addr;
    logic              full;
    logic [2:0]        count;
    logic              overflow;

    int n_pass = 0;
    int n_total = 0;

    logic [ADDR_W-1:0] mq[$];
    bit                m_ovf = 0;

    instr_inv_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .push(push), .push_addr(push_addr),
        .clear(clear), .inv_valid(inv_valid), .inv_addr(inv_addr),
        .inv_completed(inv_completed), .full(full), .count(count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Drive one cycle and advance the reference queue by the queue rules.
    task automatic step(input bit p, input logic [ADDR_W-1:0] a,
                        input bit c, input bit comp, input bit r);
        bit pop;
        bit hit;
        int first;
        push = p; push_addr = a; clear = c; inv_completed = comp; rst = r;
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_ovf = 0;
        end else begin
            pop = comp && (mq.size() > 0);
            if (c) while (mq.size() > 1) void'(mq.pop_back());
            if (pop) void'(mq.pop_front());
            first = pop ? 0 : 1;
            hit = 0;
            if (p) begin
                for (int i = first; i < mq.size(); i++)
                    if (mq[i] == a) hit = 1;
                if (!hit) begin
                    if (mq.size() < DEPTH) mq.push_back(a);
                    else m_ovf = 1;
                end
            end
        end
        #1;
        push = 0; clear = 0; inv_completed = 0; rst = 0;
    endtask

    task automatic test_reset();
        step(1, 30'h55, 1, 1, 1);
        step(0, 0, 0, 0, 1);
        n_total++;
        if (inv_valid !== 1'b0 || count !== 3'd0 || full !== 1'b0 ||
            overflow !== 1'b0)
            $display("FAIL reset: valid=%b count=%0d full=%b ovf=%b want 0/0/0/0",
                     inv_valid, count, full, overflow);
        else n_pass++;
        step(0, 0, 0, 1, 0);
        n_total++;
        if (count !== 3'd0 || inv_valid !== 1'b0)
            $display("FAIL idle_complete: count=%0d valid=%b want 0/0",
                     count, inv_valid);
        else n_pass++;
    endtask

    task automatic test_basic();
        step(0, 0, 0, 0, 1);
        step(1, 30'h100, 0, 0, 0);
        n_total++;
        if (inv_valid !== 1'b1 || inv_addr !== 30'h100 || count !== 3'd1)
            $display("FAIL basic_push: valid=%b addr=%h count=%0d want 1/100/1",
                     inv_valid, inv_addr, count);
        else n_pass++;
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        n_total++;
        if (inv_valid !== 1'b1 || inv_addr !== 30'h100)
            $display("FAIL basic_hold: valid=%b addr=%h want 1/100",
                     inv_valid, inv_addr);
        else n_pass++;
        step(0, 0, 0, 1, 0);
        n_total++;
        if (inv_valid !== 1'b0 || count !== 3'd0)
            $display("FAIL basic_pop: valid=%b count=%0d want 0/0",
                     inv_valid, count);
        else n_pass++;
    endtask

    task automatic test_coalesce();
        logic [ADDR_W-1:0] exp [3];
        exp[0] = 30'h100; exp[1] = 30'h200; exp[2] = 30'h100;
        step(0, 0, 0, 0, 1);
        step(1, 30'h100, 0, 0, 0);
        step(1, 30'h200, 0, 0, 0);
        step(1, 30'h200, 0, 0, 0);
        step(1, 30'h100, 0, 0, 0);
        n_total++;
        if (count !== 3'd3 || overflow !== 1'b0)
            $display("FAIL coalesce_count: count=%0d ovf=%b want 3/0",
                     count, overflow);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            n_total++;
            if (inv_valid !== 1'b1 || inv_addr !== exp[i])
                $display("FAIL coalesce_order%0d: valid=%b addr=%h want 1/%h",
                         i, inv_valid, inv_addr, exp[i]);
            else n_pass++;
            step(0, 0, 0, 1, 0);
        end
    endtask

    task automatic test_overflow();
        logic [ADDR_W-1:0] exp [4];
        exp[0] = 30'h2; exp[1] = 30'h3; exp[2] = 30'h4; exp[3] = 30'h6;
        step(0, 0, 0, 0, 1);
        for (int i = 1; i <= 4; i++) step(1, ADDR_W'(i), 0, 0, 0);
        n_total++;
        if (full !== 1'b1 || count !== 3'd4)
            $display("FAIL ovf_full: full=%b count=%0d want 1/4", full, count);
        else n_pass++;
        step(1, 30'h5, 0, 0, 0);
        n_total++;
        if (overflow !== 1'b1 || count !== 3'd4 || inv_addr !== 30'h1)
            $display("FAIL ovf_drop: ovf=%b count=%0d addr=%h want 1/4/1",
                     overflow, count, inv_addr);
        else n_pass++;
        step(1, 30'h6, 0, 1, 0);
        n_total++;
        if (count !== 3'd4 || full !== 1'b1)
            $display("FAIL ovf_pushpop: count=%0d full=%b want 4/1", count, full);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (inv_valid !== 1'b1 || inv_addr !== exp[i])
                $display("FAIL ovf_order%0d: valid=%b addr=%h want 1/%h",
                         i, inv_valid, inv_addr, exp[i]);
            else n_pass++;
            step(0, 0, i == 3, 1, 0);
        end
        n_total++;
        if (count !== 3'd0 || overflow !== 1'b1)
            $display("FAIL ovf_sticky: count=%0d ovf=%b want 0/1", count, overflow);
        else n_pass++;
    endtask

    task automatic test_clear();
        step(0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0);
        n_total++;
        if (count !== 3'd0 || inv_valid !== 1'b0)
            $display("FAIL clear_empty: count=%0d valid=%b want 0/0",
                     count, inv_valid);
        else n_pass++;
        step(1, 30'hA, 0, 0, 0);
        step(1, 30'h1, 0, 0, 0);
        step(1, 30'h2, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        n_total++;
        if (count !== 3'd1 || inv_addr !== 30'hA || inv_valid !== 1'b1)
            $display("FAIL clear_keep: count=%0d addr=%h want 1/a",
                     count, inv_addr);
        else n_pass++;
        step(1, 30'hB, 1, 1, 0);
        n_total++;
        if (count !== 3'd1 || inv_addr !== 30'hB)
            $display("FAIL clear_pop_push: count=%0d addr=%h want 1/b",
                     count, inv_addr);
        else n_pass++;
        step(1, 30'h1, 0, 0, 0);
        step(1, 30'h1, 1, 0, 0);
        n_total++;
        if (count !== 3'd2 || inv_addr !== 30'hB)
            $display("FAIL clear_push_survivor: count=%0d addr=%h want 2/b",
                     count, inv_addr);
        else n_pass++;
        step(1, 30'hB, 1, 0, 0);
        n_total++;
        if (count !== 3'd2 || inv_addr !== 30'hB)
            $display("FAIL clear_push_head: count=%0d addr=%h want 2/b",
                     count, inv_addr);
        else n_pass++;
    endtask

    task automatic test_random();
        bit p, c, k;
        step(0, 0, 0, 0, 1);
        for (int cyc = 0; cyc < 300; cyc++) begin
            p = ($urandom_range(9) < 6);
            c = ($urandom_range(19) == 0);
            k = ($urandom_range(9) < 4);
            step(p, ADDR_W'($urandom_range(5)), c, k, 0);
            n_total++;
            if (inv_valid !== (mq.size() > 0) || count !== 3'(mq.size()) ||
                full !== (mq.size() == DEPTH) || overflow !== m_ovf)
                $display("FAIL rand_state cyc%0d: v=%b n=%0d f=%b o=%b want n=%0d o=%b",
                         cyc, inv_valid, count, full, overflow, mq.size(), m_ovf);
            else n_pass++;
            if (mq.size() > 0) begin
                n_total++;
                if (inv_addr !== mq[0])
                    $display("FAIL rand_head cyc%0d: addr=%h want %h",
                             cyc, inv_addr, mq[0]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_wrap();
        logic [ADDR_W-1:0] sent[$];
        logic [ADDR_W-1:0] got[$];
        logic [ADDR_W-1:0] pa;
        bit pv, p, k;
        int nxt = 0;
        int cyc = 0;
        step(0, 0, 0, 0, 1);
        while ((nxt < 3*DEPTH || mq.size() > 0) && cyc < 200) begin
            p = (nxt < 3*DEPTH) && ($urandom_range(1) == 1);
            k = ($urandom_range(1) == 1);
            if (p && mq.size() == DEPTH && !k) p = 0;
            if (p) sent.push_back(ADDR_W'(30'h3000 + nxt));
            if (k && inv_valid) got.push_back(inv_addr);
            pv = inv_valid; pa = inv_addr;
            step(p, ADDR_W'(30'h3000 + nxt), 0, k, 0);
            if (p) nxt++;
            n_total++;
            if (count > 3'(DEPTH) || count !== 3'(mq.size()))
                $display("FAIL wrap_count cyc%0d: count=%0d want %0d",
                         cyc, count, mq.size());
            else n_pass++;
            if (pv && !k) begin
                n_total++;
                if (inv_valid !== 1'b1 || inv_addr !== pa)
                    $display("FAIL wrap_stable cyc%0d: v=%b addr=%h want 1/%h",
                             cyc, inv_valid, inv_addr, pa);
                else n_pass++;
            end
            cyc++;
        end
        n_total++;
        if (cyc >= 200 || got.size() != 3*DEPTH || got != sent)
            $display("FAIL wrap_order: popped=%0d of %0d cycles=%0d",
                     got.size(), sent.size(), cyc);
        else n_pass++;
        step(1, 30'h7, 0, 0, 0);
        step(1, 30'h8, 0, 0, 0);
        step(1, 30'h9, 0, 0, 0);
        step(1, 30'hA, 0, 0, 0);
        step(1, 30'hB, 0, 0, 0);
        step(1, 30'hC, 1, 1, 1);
        n_total++;
        if (inv_valid !== 1'b0 || count !== 3'd0 || full !== 1'b0 ||
            overflow !== 1'b0)
            $display("FAIL wrap_rst: v=%b n=%0d f=%b o=%b want 0/0/0/0",
                     inv_valid, count, full, overflow);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_coalesce();
        test_overflow();
        test_clear();
        test_random();
        test_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: sim time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/instr_inv_queue.md
INSTR_INV_QUEUE -- requirements
Module: instr_inv_queue

Interface
- REQ-001: Parameter DEPTH, default 4, number of queue entries; power of two, minimum 2.
- REQ-002: Parameter ADDR_W, default 30, word-address width (byte address bits [31:2]).
- REQ-003: clk  input  1  clock; all state changes on rising edge.
- REQ-004: rst  input  1  reset, synchronous, active-high.
- REQ-005: push  input  1  request to enqueue an invalidation address (store to instruction memory observed).
- REQ-006: push_addr  input  ADDR_W  word address to invalidate.
- REQ-007: clear  input  1  drop all pending non-head entries (fence.i-style flush of stale work).
- REQ-008: inv_valid  output  1  head entry presented to the branch-predictor invalidation sink.
- REQ-009: inv_addr  output  ADDR_W  head entry word address.
- REQ-010: inv_completed  input  1  sink has finished the head entry; pop it.
- REQ-011: full  output  1  count == DEPTH.
- REQ-012: count  output  $clog2(DEPTH+1)  number of valid entries.
- REQ-013: overflow  output  1  sticky; a push was dropped for lack of space.

Function
- REQ-014: Storage is a circular buffer with head and tail pointers of $clog2(DEPTH) bits plus a count register; pointers wrap from DEPTH-1 to 0.
- REQ-015: inv_valid is driven from count != 0; inv_addr is the head entry; both are registered-state outputs with no combinational path from push, push_addr or clear.
- REQ-016: A pushed address is visible on inv_valid/inv_addr no earlier than the cycle after the push.
- REQ-017: Once inv_valid is asserted, inv_valid and inv_addr are held stable until the cycle inv_completed is sampled high, regardless of push, clear or overflow.
- REQ-018: inv_completed sampled while inv_valid is low is ignored (no pointer or count change).
- REQ-019: Coalescing: a push whose push_addr equals any valid non-head entry is absorbed (no enqueue, no count change, no overflow).
- REQ-020: A push equal to the head entry is enqueued normally, since the sink may already have completed its lookup of that address.
- REQ-021: A non-coalesced push is accepted if count < DEPTH, or if count == DEPTH and inv_completed pops the head in the same cycle.
- REQ-022: A non-coalesced push when count == DEPTH and no pop occurs is dropped and sets overflow.
- REQ-023: Simultaneous accepted push and pop leave count unchanged and advance both pointers.
- REQ-024: For coalescing in a pop cycle, the entry behind the departing head counts as non-head.
- REQ-025: clear sets count to 1 and tail to head+1 if count != 0 and no pop occurs, preserving the head in progress.
- REQ-026: clear sets count to 0 and tail to head+1 if count != 0 and the head pops in the same cycle.
- REQ-027: clear with count == 0 has no effect.
- REQ-028: A push in a clear cycle is evaluated after the clear: coalescing is checked against surviving entries only, and the push is enqueued into the post-clear state.
- REQ-029: overflow stays set until rst and is not cleared by clear.

Reset
- REQ-030: On rst: head=0, tail=0, count=0, inv_valid=0, full=0, overflow=0.
- REQ-031: Entry contents are not reset; inv_addr is don't-care while inv_valid=0.
- REQ-032: rst mid-handshake abandons the head entry; the sink's own reset covers its state.
- REQ-033: rst has priority over push, clear and inv_completed.

Verification
- REQ-034: Push 0x100 at cycle 0 -> inv_valid=1, inv_addr=0x100, count=1 at cycle 1; pulse inv_completed at cycle 3 -> inv_valid=0, count=0 at cycle 4.
- REQ-035: With head 0x100 stalled, push 0x200 twice and then 0x100 -> count=3 (entries 0x100, 0x200, 0x100); the second 0x200 is coalesced.
- REQ-036: With DEPTH=4 and the queue full of 0x1-0x4: push 0x5 -> dropped, overflow=1; push 0x6 with inv_completed -> accepted, count=4; pop order is 0x2, 0x3, 0x4, 0x6.
- REQ-037: With count=3 and head 0xA held: assert clear -> count=1, inv_addr=0xA unchanged; assert clear, inv_completed and push 0xB together -> count=1, head=0xB next cycle.
- REQ-038: Wrap stress: 3*DEPTH random pushes/pops with no duplicates -> output order equals input order; count never exceeds DEPTH; inv_addr stable while inv_valid and no inv_completed; a rst pulse mid-stream -> all outputs return to reset values the next cycle.
